br_redirect_ctrl: RTL
=====================

Name: br_redirect_ctrl

Overview:
- Sequences the consequences of each resolved branch from the execute-stage branch unit.
- Arbitrates PC redirects to fetch between a branch mispredict and an exception/ertn redirect, holding the winner until fetch accepts it.
- Emits one-cycle pipeline flush pulses.
- Queues predictor-update records for the BTB/PHT in a small FIFO.

Parameters:
- UPD_DEPTH, 4: update-FIFO entries; power of two, at least 2.
- ADDR_W, 32: PC and target width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- br_valid  in  1  resolved branch present in execute this cycle
- br_ifbr  in  1  mispredict; redirect required
- br_flush_pre  in  1  prediction correct, but the single pre-fetched slot must be dropped
- br_taken  in  1  actual direction
- br_pc  in  ADDR_W  branch PC
- br_target  in  ADDR_W  corrected next PC
- exc_valid  in  1  exception/ertn redirect request
- exc_target  in  ADDR_W  exception/ertn entry PC
- redir_ready  in  1  fetch accepts redirect
- redir_valid  out  1  redirect pending
- redir_pc  out  ADDR_W  redirect target
- flush_if  out  1  one-cycle pulse
- flush_id  out  1  one-cycle pulse
- flush_ex  out  1  one-cycle pulse
- br_stall_req  out  1  execute must hold its branch (combinational)
- upd_valid  out  1  FIFO head valid
- upd_ready  in  1  predictor consumes head
- upd_pc  out  ADDR_W  head branch PC
- upd_target  out  ADDR_W  head target
- upd_taken  out  1  head direction

Behaviour:
- Reset: asynchronous on rstn low; state IDLE; FIFO emptied; all outputs 0, including redir_pc.
- Reset mid-HOLD drops the pending redirect; no flush is emitted on release.
- FSM states: IDLE and HOLD.
- IDLE, exc_valid:
  - Capture exc_target into redir_pc.
  - Next cycle: redir_valid=1; flush_if, flush_id and flush_ex pulse for that one cycle; go to HOLD.
  - Any br_valid in the same cycle is wrong-path: discarded, no FIFO push.
- IDLE, br_valid & br_ifbr & no exc_valid & not stalled:
  - Capture br_target into redir_pc; push the update record.
  - Next cycle: redir_valid=1; flush_if and flush_id pulse, flush_ex stays 0; go to HOLD.
- IDLE, br_valid & !br_ifbr & br_flush_pre & not stalled: push the update record; next cycle flush_if alone pulses; no redirect; stay IDLE.
- IDLE, br_valid with neither ifbr nor flush_pre, not stalled: push the update record only.
- HOLD: redir_valid stays 1 and redir_pc stays stable until redir_ready.
  - redir_ready & !exc_valid: next cycle redir_valid=0, go to IDLE.
  - exc_valid (with or without ready): overwrite redir_pc with exc_target; next cycle pulse all three flushes; remain HOLD with redir_valid=1.
  - br_valid is ignored in HOLD (wrong path): no push, no stall.
- Latency: one cycle from qualifying input to flush pulse and redir_valid. No flush is ever longer than one cycle unless a new qualifying event occurs.
- FIFO full: full = count==UPD_DEPTH.
  - br_stall_req = br_valid & state==IDLE & !exc_valid & full & !(upd_valid & upd_ready).
  - A stalled branch causes no push, no redirect and no flush; it is re-presented by execute.
  - Push and pop in the same cycle while full are permitted; count is unchanged.
- FIFO empty: upd_valid=0; a push into an empty FIFO gives upd_valid=1 on the next cycle (no bypass).
- FIFO pointers: log2(UPD_DEPTH) bits wide, wrapping modulo UPD_DEPTH; count is log2(UPD_DEPTH)+1 bits wide.
- Update records contain {br_pc, br_target, br_taken} as presented; on a not-taken branch br_target is the sequential PC.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=0, HOLD=1) and the update-record struct {pc, target, taken}, reused by the predictor.
- One natural sub-module: br_upd_fifo, a parameterised synchronous FIFO with valid/ready output and a full flag.

Test Plan:
- Mispredict in IDLE: br_valid=1, ifbr=1, target=0x1C000040; redir_ready=1 next cycle -> next cycle redir_valid=1, redir_pc=0x1C000040, flush_if=flush_id=1, flush_ex=0; the cycle after, redir_valid=0; one FIFO entry with taken as driven.
- flush_pre only: br_valid=1, ifbr=0, flush_pre=1, pc=0x1C000008 -> one-cycle flush_if only, redir_valid stays 0, upd_pc=0x1C000008 the next cycle.
- Exception overrides a held redirect: mispredict to 0x100 with redir_ready=0, then exc_valid with target 0x1C008000 two cycles later -> redir_pc changes to 0x1C008000, all three flushes pulse once, redir_valid held until ready.
- Simultaneous events: exc_valid and mispredict in the same IDLE cycle -> redir_pc=exc_target, no FIFO push.
- FIFO full: upd_ready=0, push 4 branches, present a 5th -> br_stall_req=1 and count=4; raise upd_ready -> stall drops the same cycle, the push completes, count stays 4.
- Async reset asserted mid-HOLD -> redir_valid=0, flushes=0 and upd_valid=0 immediately; after release, state is IDLE and no pulse is emitted.

Source files
------------

// File: rtl/br_redirect_ctrl_pkg.sv
// Shared types for branch redirect control and the branch predictor.
// State encoding, update-record layout and record width helper.
package br_redirect_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } redir_state_e;

  localparam int REC_ADDR_W = 32;

  typedef struct packed {
    logic [REC_ADDR_W-1:0] pc;
    logic [REC_ADDR_W-1:0] target;
    logic                  taken;
  } upd_rec_t;

  // flush vector order: {if, id, ex}
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_PRE  = 3'b100;
  localparam logic [2:0] FL_MISP = 3'b110;
  localparam logic [2:0] FL_EXC  = 3'b111;

  function automatic int rec_w(input int aw);
    return 2 * aw + 1;
  endfunction

endpackage

// File: rtl/br_upd_fifo.sv
// Synchronous FIFO for predictor update records; valid/ready head, full flag.
// Ports: clk, rstn, push, push_data, full, valid, ready, data.
module br_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 65
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          full,
  output logic          valid,
  input  logic          ready,
  output logic [DW-1:0] data
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          pop;
  logic          do_push;

  assign valid   = count != '0;
  assign full    = count == (PW+1)'(DEPTH);
  assign pop     = valid & ready;
  // a pop frees the slot in the same cycle, so full+pop may push
  assign do_push = push & (~full | pop);
  assign data    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count <= count
             + (PW+1)'(do_push)
             - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/br_redirect_ctrl.sv
// Sequences resolved branches: redirect arbitration, flush pulses, predictor updates.
// Ports: branch/exception inputs, redirect handshake, flush pulses, stall, update FIFO head.
module br_redirect_ctrl
  import br_redirect_ctrl_pkg::*;
#(
  parameter int UPD_DEPTH = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              br_valid,
  input  logic              br_ifbr,
  input  logic              br_flush_pre,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_target,
  input  logic              redir_ready,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_pc,
  output logic              flush_if,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              br_stall_req,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [ADDR_W-1:0] upd_pc,
  output logic [ADDR_W-1:0] upd_target,
  output logic              upd_taken
);
  localparam int RW = rec_w(ADDR_W);

  redir_state_e      state_q;
  redir_state_e      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [2:0]        fl_q;
  logic [2:0]        fl_d;
  logic              full;
  logic              br_go;
  logic [RW-1:0]     head;

  assign br_stall_req = br_valid & (state_q == IDLE)
                      & ~exc_valid & full
                      & ~(upd_valid & upd_ready);
  // branch that is on the right path and fits in the FIFO
  assign br_go = br_valid & (state_q == IDLE)
               & ~exc_valid & ~br_stall_req;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fl_d    = FL_NONE;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          exc_valid: begin
            state_d = HOLD;
            pc_d    = exc_target;
            fl_d    = FL_EXC;
          end
          br_go & br_ifbr: begin
            state_d = HOLD;
            pc_d    = br_target;
            fl_d    = FL_MISP;
          end
          br_go & ~br_ifbr & br_flush_pre: begin
            fl_d = FL_PRE;
          end
          default: ;
        endcase
      end
      HOLD: begin
        unique case (1'b1)
          exc_valid: begin
            pc_d = exc_target;
            fl_d = FL_EXC;
          end
          redir_ready & ~exc_valid: begin
            state_d = IDLE;
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fl_q    <= FL_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fl_q    <= fl_d;
    end
  end

  assign redir_valid = state_q == HOLD;
  assign redir_pc    = pc_q;
  assign flush_if    = fl_q[2];
  assign flush_id    = fl_q[1];
  assign flush_ex    = fl_q[0];

  br_upd_fifo #(
    .DEPTH (UPD_DEPTH),
    .DW    (RW)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (br_go),
    .push_data ({br_pc, br_target, br_taken}),
    .full      (full),
    .valid     (upd_valid),
    .ready     (upd_ready),
    .data      (head)
  );

  assign upd_pc     = head[RW-1 -: ADDR_W];
  assign upd_target = head[ADDR_W:1];
  assign upd_taken  = head[0];

endmodule
